// File: rtl/tb_uart_pkg.sv
// Shared definitions for the tb_uart transceiver: FSM state encoding and 8N1 frame constants.
package tb_uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

  localparam int   DATA_BITS  = 8;
  localparam logic STOP_LEVEL = 1'b1;

endpackage

// File: rtl/tb_uart_if.sv
// Handshake and serial signal bundle between the bench-side requester (master) and tb_uart (slave).
interface tb_uart_if;
  import tb_uart_pkg::*;

  logic                 tx_start;
  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_busy;
  logic                 tx_clear_req;
  logic                 ser_tx;
  logic                 ser_rx;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_frame_err;

  modport master (
    output tx_start, tx_data, ser_rx,
    input  tx_busy, tx_clear_req, ser_tx, rx_data, rx_valid, rx_frame_err
  );

  modport slave (
    input  tx_start, tx_data, ser_rx,
    output tx_busy, tx_clear_req, ser_tx, rx_data, rx_valid, rx_frame_err
  );

endinterface

// File: rtl/tb_uart_rx.sv
// 8N1 receiver: 2-flop synchronizer, start validation at mid-bit, mid-bit data sampling, stop check.
module tb_uart_rx
  import tb_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 347
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 ser_rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 rx_frame_err
);

  localparam int               CNT_W     = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [2:0]       BIT_LAST  = 3'(DATA_BITS - 1);

  uart_state_e          rx_state, rx_state_nxt;
  logic                 rx_meta, rx_sync, rx_sync_q;
  logic [CNT_W-1:0]     rx_baud_cnt;
  logic [2:0]           rx_bit_cnt;
  logic [DATA_BITS-1:0] rx_shreg;
  logic                 fall, half_hit, baud_last;
  logic                 shift_bit, frame_ok, frame_bad;

  // Synchronizer flops reset to the idle (high) level so reset never fakes a start edge
  always_ff @(posedge clock) begin
    if (reset) begin
      rx_meta   <= 1'b1;
      rx_sync   <= 1'b1;
      rx_sync_q <= 1'b1;
    end else begin
      rx_meta   <= ser_rx;
      rx_sync   <= rx_meta;
      rx_sync_q <= rx_sync;
    end
  end

  assign fall      = rx_sync_q & ~rx_sync;
  assign half_hit  = (rx_baud_cnt == HALF_LAST);
  assign baud_last = (rx_baud_cnt == BAUD_LAST);

  always_ff @(posedge clock) begin
    if (reset) rx_state <= IDLE;
    else       rx_state <= rx_state_nxt;
  end

  always_comb begin
    rx_state_nxt = rx_state;
    case (rx_state)
      IDLE:  if (fall) rx_state_nxt = START;
      START: if (half_hit) rx_state_nxt = rx_sync ? IDLE : DATA;
      DATA:  if (baud_last && (rx_bit_cnt == BIT_LAST)) rx_state_nxt = STOP;
      STOP:  if (baud_last) rx_state_nxt = IDLE;
      default: rx_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    shift_bit = (rx_state == DATA) && baud_last;
    frame_ok  = (rx_state == STOP) && baud_last && (rx_sync == STOP_LEVEL);
    frame_bad = (rx_state == STOP) && baud_last && (rx_sync != STOP_LEVEL);
  end

  // START counts half a bit, so every later wrap lands on a bit centre
  always_ff @(posedge clock) begin
    if (reset || (rx_state == IDLE)) begin
      rx_baud_cnt <= '0;
      rx_bit_cnt  <= '0;
    end else if ((rx_state == START) ? half_hit : baud_last) begin
      rx_baud_cnt <= '0;
      if (rx_state == DATA) rx_bit_cnt <= rx_bit_cnt + 3'd1;
    end else begin
      rx_baud_cnt <= rx_baud_cnt + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (shift_bit) rx_shreg <= {rx_sync, rx_shreg[DATA_BITS-1:1]};
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rx_data      <= '0;
      rx_valid     <= 1'b0;
      rx_frame_err <= 1'b0;
    end else begin
      if (frame_ok) rx_data <= rx_shreg;
      rx_valid     <= frame_ok;
      rx_frame_err <= frame_bad;
    end
  end

endmodule

// File: rtl/tb_uart.sv
// tb_uart: full-duplex 8N1 UART bench partner; TX FSM lives here, receiver in tb_uart_rx.
// Define TB_UART_RX_EN to compile in the receiver; otherwise ser_rx is ignored and RX outputs read 0.
module tb_uart
  import tb_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 347
) (
  input logic      clock,
  input logic      reset,
  tb_uart_if.slave bus
);

  localparam int               CNT_W     = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]       BIT_LAST  = 3'(DATA_BITS - 1);

  uart_state_e          tx_state, tx_state_nxt;
  logic [CNT_W-1:0]     tx_baud_cnt;
  logic [2:0]           tx_bit_cnt;
  logic [DATA_BITS-1:0] tx_shreg;
  logic                 tx_start_q, tx_clear_req_q;
  logic                 start_rise, baud_last;
  logic                 tx_busy_c, ser_tx_c;

  assign start_rise = bus.tx_start & ~tx_start_q;
  assign baud_last  = (tx_baud_cnt == BAUD_LAST);

  always_ff @(posedge clock) begin
    if (reset) begin
      tx_state   <= IDLE;
      tx_start_q <= 1'b0;
    end else begin
      tx_state   <= tx_state_nxt;
      tx_start_q <= bus.tx_start;
    end
  end

  // Only a fresh rising edge seen in IDLE launches a frame; edges while busy are dropped
  always_comb begin
    tx_state_nxt = tx_state;
    case (tx_state)
      IDLE:  if (start_rise) tx_state_nxt = START;
      START: if (baud_last) tx_state_nxt = DATA;
      DATA:  if (baud_last && (tx_bit_cnt == BIT_LAST)) tx_state_nxt = STOP;
      STOP:  if (baud_last) tx_state_nxt = IDLE;
      default: tx_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    tx_busy_c = 1'b1;
    ser_tx_c  = 1'b1;
    case (tx_state)
      IDLE:    tx_busy_c = 1'b0;
      START:   ser_tx_c  = 1'b0;
      DATA:    ser_tx_c  = tx_shreg[0];
      STOP:    ser_tx_c  = STOP_LEVEL;
      default: tx_busy_c = 1'b0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset || (tx_state == IDLE)) begin
      tx_baud_cnt <= '0;
      tx_bit_cnt  <= '0;
    end else if (baud_last) begin
      tx_baud_cnt <= '0;
      if (tx_state == DATA) tx_bit_cnt <= tx_bit_cnt + 3'd1;
    end else begin
      tx_baud_cnt <= tx_baud_cnt + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if ((tx_state == IDLE) && start_rise)        tx_shreg <= bus.tx_data;
    else if ((tx_state == DATA) && baud_last)    tx_shreg <= tx_shreg >> 1;
  end

  // Registered so the pulse coincides with the first cycle tx_busy reads low
  always_ff @(posedge clock) begin
    if (reset) tx_clear_req_q <= 1'b0;
    else       tx_clear_req_q <= (tx_state == STOP) && baud_last;
  end

  assign bus.tx_busy      = tx_busy_c;
  assign bus.ser_tx       = ser_tx_c;
  assign bus.tx_clear_req = tx_clear_req_q;

`ifdef TB_UART_RX_EN
  tb_uart_rx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clock       (clock),
    .reset       (reset),
    .ser_rx      (bus.ser_rx),
    .rx_data     (bus.rx_data),
    .rx_valid    (bus.rx_valid),
    .rx_frame_err(bus.rx_frame_err)
  );
`else
  assign bus.rx_data      = '0;
  assign bus.rx_valid     = 1'b0;
  assign bus.rx_frame_err = 1'b0;
`endif

endmodule

// File: tb/tb_tb_uart.sv
// Scoreboard bench for tb_uart: a line decoder checks every TX frame, a monitor checks RX outputs.
module tb_tb_uart;

  localparam int CPB = 347;
`ifdef TB_UART_RX_EN
  localparam bit RX_EN = 1'b1;
`else
  localparam bit RX_EN = 1'b0;
`endif

  logic clock    = 1'b0;
  logic reset    = 1'b1;
  logic loop_en  = 1'b1;
  logic rx_force = 1'b1;

  int checks   = 0;
  int errors   = 0;
  int rst_gen  = 0;
  int rx_cnt   = 0;
  int ferr_cnt = 0;

  logic [7:0] tx_exp_q[$];
  logic [7:0] rx_exp_q[$];
  logic [7:0] last_rx = 8'h00;

  tb_uart_if bus ();

  assign bus.ser_rx = loop_en ? bus.ser_tx : rx_force;

  tb_uart #(
    .CLKS_PER_BIT(CPB)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_clear(input string name);
    int n;
    n = 0;
    while ((bus.tx_clear_req !== 1'b1) && (n < 12 * CPB)) begin
      @(negedge clock);
      n++;
    end
    chk({name, " completes in time"}, int'(n < 12 * CPB), 1);
  endtask

  task automatic frame(input logic [7:0] d, input bit glitch);
    @(posedge clock); #1;
    bus.tx_data  = d;
    bus.tx_start = 1'b1;
    tx_exp_q.push_back(d);
    if (RX_EN) rx_exp_q.push_back(d);
    if (glitch) begin
      // Re-request and change data mid-frame: both must be ignored
      repeat (3 * CPB) @(posedge clock); #1;
      bus.tx_data  = ~d;
      bus.tx_start = 1'b0;
      @(posedge clock); #1;
      bus.tx_start = 1'b1;
    end
    wait_clear("frame");
    @(posedge clock); #1;
    bus.tx_start = 1'b0;
    repeat (60) @(posedge clock);
  endtask

  // TX decoder: sample each bit at its centre and check the frame tail timing
  initial begin : tx_mon
    forever begin
      @(negedge clock);
      if (!reset && (bus.ser_tx === 1'b0)) begin
        int         g;
        logic [9:0] bits;
        logic       busy_end, busy_after, clr_after, clr_late;
        logic [7:0] exp;
        g = rst_gen;
        repeat (CPB / 2) @(negedge clock);
        for (int i = 0; i < 10; i++) begin
          bits[i] = bus.ser_tx;
          if (i < 9) repeat (CPB) @(negedge clock);
        end
        repeat (CPB - CPB / 2 - 1) @(negedge clock);
        busy_end = bus.tx_busy;
        @(negedge clock);
        busy_after = bus.tx_busy;
        clr_after  = bus.tx_clear_req;
        @(negedge clock);
        clr_late = bus.tx_clear_req;
        if (tx_exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL tx_unexpected_frame: got data %02h, expected no frame", bits[8:1]);
        end else begin
          exp = tx_exp_q.pop_front();
          if (g == rst_gen) begin
            chk("tx start bit", int'(bits[0]), 0);
            chk("tx data bits", int'(bits[8:1]), int'(exp));
            chk("tx stop bit", int'(bits[9]), 1);
            chk("tx_busy in last frame cycle", int'(busy_end), 1);
            chk("tx_busy falls after 10 bits", int'(busy_after), 0);
            chk("tx_clear_req with busy fall", int'(clr_after), 1);
            chk("tx_clear_req one cycle", int'(clr_late), 0);
          end
        end
      end
    end
  end

  always @(negedge clock) begin
    if (!reset && bus.rx_valid) begin
      rx_cnt++;
      chk("rx_valid and rx_frame_err exclusive", int'(bus.rx_frame_err), 0);
      if (rx_exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rx_unexpected_valid: got rx_data %02h, expected no output", bus.rx_data);
      end else begin
        last_rx = rx_exp_q.pop_front();
        chk("rx_data", int'(bus.rx_data), int'(last_rx));
      end
    end
    if (!reset && bus.rx_frame_err) begin
      ferr_cnt++;
      chk("rx_data held on frame error", int'(bus.rx_data), int'(last_rx));
    end
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: got simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int         bad;
    int         rx0;
    logic [9:0] ef;
    bus.tx_start = 1'b0;
    bus.tx_data  = 8'h00;
    repeat (3) @(posedge clock); #1;
    chk("reset ser_tx", int'(bus.ser_tx), 1);
    chk("reset tx_busy", int'(bus.tx_busy), 0);
    chk("reset tx_clear_req", int'(bus.tx_clear_req), 0);
    chk("reset rx_data", int'(bus.rx_data), 0);
    chk("reset rx_valid", int'(bus.rx_valid), 0);
    chk("reset rx_frame_err", int'(bus.rx_frame_err), 0);
    reset = 1'b0;

    bad = 0;
    repeat (1000) begin
      @(negedge clock);
      if ((bus.ser_tx !== 1'b1) || (bus.tx_busy !== 1'b0)) bad++;
    end
    chk("idle line after reset", bad, 0);

    @(posedge clock); #1;
    bus.tx_data  = 8'h03;
    bus.tx_start = 1'b1;
    tx_exp_q.push_back(8'h03);
    if (RX_EN) rx_exp_q.push_back(8'h03);
    chk("tx_busy before request sampled", int'(bus.tx_busy), 0);
    repeat (2) @(posedge clock); #1;
    chk("tx_busy 2 cycles after request", int'(bus.tx_busy), 1);
    chk("start bit on ser_tx", int'(bus.ser_tx), 0);
    wait_clear("first frame");

    bad = 0;
    repeat (1000) begin
      @(negedge clock);
      if ((bus.ser_tx !== 1'b1) || (bus.tx_busy !== 1'b0)) bad++;
    end
    chk("held tx_start does not retrigger", bad, 0);
    @(posedge clock); #1;
    bus.tx_start = 1'b0;
    repeat (20) @(posedge clock);

    for (int v = 1; v <= 10; v++) frame(8'(v), v == 5);

    loop_en  = 1'b0;
    rx_force = 1'b1;
    @(posedge clock); #1;
    rx_force = 1'b0;
    repeat (100) @(posedge clock); #1;
    rx_force = 1'b1;
    rx0 = rx_cnt;
    repeat (2 * CPB) @(posedge clock); #1;
    chk("false start gives no rx_valid", rx_cnt - rx0, 0);

    ef = {1'b0, 8'hA5, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx_force = ef[i];
      repeat (CPB) @(posedge clock); #1;
    end
    rx_force = 1'b1;
    repeat (CPB) @(posedge clock); #1;
    chk("frame error pulse count", ferr_cnt, RX_EN ? 1 : 0);
    chk("rx_data kept after frame error", int'(bus.rx_data), RX_EN ? 8'h0A : 0);
    chk("no rx_valid for bad frame", rx_cnt - rx0, 0);
    loop_en = 1'b1;
    repeat (20) @(posedge clock);

    @(posedge clock); #1;
    bus.tx_data  = 8'hC3;
    bus.tx_start = 1'b1;
    tx_exp_q.push_back(8'hC3);
    repeat (4 * CPB + CPB / 2) @(posedge clock); #1;
    chk("ser_tx low in bit 4", int'(bus.ser_tx), 0);
    reset        = 1'b1;
    rst_gen      = rst_gen + 1;
    bus.tx_start = 1'b0;
    @(posedge clock); #1;
    chk("ser_tx after mid-frame reset", int'(bus.ser_tx), 1);
    chk("tx_busy after mid-frame reset", int'(bus.tx_busy), 0);
    repeat (2) @(posedge clock); #1;
    reset = 1'b0;
    repeat (11 * CPB) @(posedge clock);
    frame(8'h5A, 1'b0);

    repeat (200) @(posedge clock);
    chk("tx scoreboard drained", tx_exp_q.size(), 0);
    chk("rx scoreboard drained", rx_exp_q.size(), 0);
    chk("rx_valid pulse count", rx_cnt, RX_EN ? 12 : 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
